plp_bus_master: RTL
===================

Name: plp_bus_master

Overview:
Serial-command bus initiator; the initiator end of the CPU data-bus protocol that the arbiter decodes.
- Consumes a byte stream (from the UART receive path) carrying read/write commands.
- Requests the data bus from the CPU, then issues single word reads or writes with the same address/data/drw semantics the CPU uses.
- Returns a response byte stream. Used as the bootloader/debug master for loading RAM and peeking/poking modules.

Parameters:
READ_LAT, 1, cycles between driving a read address (with grant held) and sampling bus_din; legal range 1..15.
CMD_WRITE, 8'h57, command byte for a word write.
CMD_READ, 8'h52, command byte for a word read.
ACK_BYTE, 8'h06, response byte after a completed write.
NAK_BYTE, 8'h15, response byte for an unrecognised command.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst  in  1  reset; asynchronous, active-low (rst=0 resets).
rx_data  in  8  incoming command byte.
rx_valid  in  1  rx_data valid; byte consumed when rx_valid & rx_ready.
rx_ready  out  1  master can accept a byte.
tx_data  out  8  outgoing response byte.
tx_valid  out  1  tx_data valid; held with tx_data stable until tx_ready.
tx_ready  in  1  sink accepts tx_data this cycle.
bus_req  out  1  request ownership of the data bus.
bus_gnt  in  1  ownership granted; held high while bus_req is high.
bus_daddr  out  32  data address, word aligned (bits 1:0 always 0).
bus_dout  out  32  write data toward the bus.
bus_din  in  32  read data from the bus.
bus_drw  out  1  1 = write, 0 = read; high for exactly one cycle per write.
busy  out  1  high in any state other than IDLE.

Behaviour:
Reset (rst low, asynchronous):
- State IDLE; byte counter, address, data and response registers all 0.
- Outputs: rx_ready=1, tx_valid=0, tx_data=0, bus_req=0, bus_daddr=0, bus_dout=0, bus_drw=0, busy=0.

States:
- IDLE: rx_ready=1. An accepted byte equal to CMD_WRITE or CMD_READ latches the opcode, clears the counter and goes to ADDR. Any other byte loads NAK_BYTE into the response register with count 1 and goes to RESP.
- ADDR: rx_ready=1. Shifts 4 bytes big-endian into the address (first byte becomes bits 31:24). After the 4th byte: write goes to DATA, read goes to REQ.
- DATA: rx_ready=1. Shifts 4 bytes big-endian into the write data, then goes to REQ.
- REQ: rx_ready=0, bus_req=1, bus_daddr = {addr[31:2],2'b00}, bus_dout = data. Waits indefinitely for bus_gnt. When bus_gnt is sampled high, goes to XFER.
- XFER, write: bus_drw=1 for one cycle, then loads ACK_BYTE (count 1) and goes to RESP.
- XFER, read: bus_drw=0. Address is held for READ_LAT cycles; bus_din is captured at the end of the last one, then loads the 4 captured bytes (count 4) and goes to RESP.
- bus_req stays high throughout XFER and drops on entry to RESP.
- RESP: rx_ready=0, bus_req=0, tx_valid=1. Bytes are sent MSB first. Advance only on tx_valid & tx_ready; after the last byte, go to IDLE with tx_valid=0 in the following cycle.

Latency:
- Write: grant to bus_drw pulse = 1 cycle; ACK presented 1 cycle after the pulse.
- Read: grant to capture = READ_LAT cycles.

Boundary conditions:
- rx_valid without rx_ready is not consumed; no bytes are buffered during REQ, XFER or RESP.
- bus_gnt already high when REQ is entered: XFER begins next cycle.
- bus_gnt dropping during XFER is a protocol violation; the master ignores it and completes the transfer.
- tx_ready held low: master stalls in RESP indefinitely with tx_data stable.
- Reset mid-transfer: bus_req and bus_drw go low immediately (asynchronously); any partial command is discarded.
- No wrap-around: address bits are taken exactly as received, with bits 1:0 masked to 0.

Decomposition:
- Shared package plp_bus_master_pkg holds the state enum (IDLE, ADDR, DATA, REQ, XFER, RESP), the opcode/ACK/NAK constants and the 2-bit byte-counter width.
- One natural sub-module: plp_byte_shifter, a 4-byte big-endian shift/serialise register used for address/data assembly and response emission. Everything else stays in a single FSM.

Test Plan:
- Write: bytes 57 00 00 10 04 DE AD BE EF, bus_gnt returned 3 cycles after bus_req -> single bus_drw pulse with bus_daddr=0x00001004, bus_dout=0xDEADBEEF; tx emits 06; busy returns to 0.
- Read: 52 00 00 00 08 with READ_LAT=1 and bus_din=0x12345678 -> bus_drw stays 0; tx emits 12 34 56 78 in order.
- Unknown command 0x41 -> tx emits 15; no bus_req; next byte 0x57 accepted normally.
- Unaligned address bytes 52 00 00 00 0B -> bus_daddr=0x00000008.
- tx_ready held low 10 cycles during a read response -> tx_data=0x12 held stable and rx_ready=0 throughout; sequence resumes intact.
- rst driven low while in XFER after write grant -> bus_req=0 and bus_drw=0 in the same cycle; after release, state is IDLE and the next command executes correctly.

Source files
------------

// File: rtl/plp_bus_master_pkg.sv
// Shared types and constants for the serial-command bus initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package plp_bus_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    REQ,
    XFER,
    RESP
  } state_t;

  // Width of the byte counter that walks the 4 bytes of a word.
  localparam int CNT_W = 2;

  localparam logic [7:0] CMD_WRITE_DEF = 8'h57;
  localparam logic [7:0] CMD_READ_DEF  = 8'h52;
  localparam logic [7:0] ACK_BYTE_DEF  = 8'h06;
  localparam logic [7:0] NAK_BYTE_DEF  = 8'h15;

  // Bus addresses are word addresses; the low two bits are never driven.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/plp_byte_shifter.sv
// 4-byte big-endian shift register: assembles words from bytes, serialises words MSB first.
// Latency: load/shift visible on word one cycle after the controlling strobe.
// Backpressure: none; the owner strobes shift only when a byte is actually transferred.
// Ports: clk/rst (async active-low), load + load_word (parallel load, has priority),
//        shift + shift_byte (word <= {word[23:0], shift_byte}), word (current contents).
module plp_byte_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        shift,
  input  logic [7:0]  shift_byte,
  output logic [31:0] word
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
    end else if (load) begin
      word <= load_word;
    end else if (shift) begin
      word <= {word[23:0], shift_byte};
    end
  end

endmodule

// File: rtl/plp_bus_master.sv
// Byte-stream command master: parses W/R commands, owns the data bus for one word, replies on tx.
// Latency: write pulse 1 cycle after grant, ACK 1 cycle later; read capture READ_LAT cycles after grant.
// Backpressure: rx_ready low outside IDLE/ADDR/DATA (no buffering); RESP holds tx_data until tx_ready.
// Ports: clk, rst (async active-low); rx_data/rx_valid/rx_ready command bytes in;
//        tx_data/tx_valid/tx_ready response bytes out; bus_req/bus_gnt ownership handshake;
//        bus_daddr/bus_dout/bus_din/bus_drw single-word bus access; busy = not IDLE.
module plp_bus_master
  import plp_bus_master_pkg::*;
#(
  parameter int unsigned READ_LAT  = 1,
  parameter logic [7:0]  CMD_WRITE = CMD_WRITE_DEF,
  parameter logic [7:0]  CMD_READ  = CMD_READ_DEF,
  parameter logic [7:0]  ACK_BYTE  = ACK_BYTE_DEF,
  parameter logic [7:0]  NAK_BYTE  = NAK_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [31:0] bus_daddr,
  output logic [31:0] bus_dout,
  input  logic [31:0] bus_din,
  output logic        bus_drw,
  output logic        busy
);

  localparam logic [3:0] LAT_LAST = 4'(READ_LAT - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] resp_last;
  logic [3:0]       lat_cnt;
  logic             is_write;

  logic        rx_fire, tx_fire, known_cmd, byte_last, xfer_done, bus_phase;
  logic        addr_shift, data_load, data_shift;
  logic [31:0] data_load_word, addr_word, data_word;
  logic [7:0]  data_shift_byte;

  assign rx_fire   = rx_valid & rx_ready;
  assign tx_fire   = tx_valid & tx_ready;
  assign known_cmd = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);
  assign byte_last = &cnt;
  // A write needs a single bus cycle; a read holds the address for READ_LAT cycles.
  assign xfer_done = is_write || (lat_cnt == LAT_LAST);
  assign bus_phase = (state == REQ) || (state == XFER);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    rx_ready   = 1'b0;
    tx_valid   = 1'b0;
    bus_req    = 1'b0;
    bus_drw    = 1'b0;
    case (state)
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) next_state = known_cmd ? ADDR : RESP;
      end
      ADDR: begin
        rx_ready = 1'b1;
        if (rx_valid && byte_last) next_state = is_write ? DATA : REQ;
      end
      DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && byte_last) next_state = REQ;
      end
      REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) next_state = XFER;
      end
      XFER: begin
        // Grant is not re-checked here: a dropped grant mid-transfer is ignored.
        bus_req = 1'b1;
        bus_drw = is_write;
        if (xfer_done) next_state = RESP;
      end
      RESP: begin
        tx_valid = 1'b1;
        if (tx_ready && (cnt == resp_last)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      resp_last <= '0;
      lat_cnt   <= '0;
      is_write  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (rx_fire) begin
          cnt       <= '0;
          resp_last <= '0;
          is_write  <= (rx_data == CMD_WRITE);
        end
        // The counter wraps to 0 after the 4th byte, ready for the next field.
        ADDR, DATA: if (rx_fire) cnt <= cnt + 1'b1;
        REQ:  lat_cnt <= '0;
        XFER: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (xfer_done) begin
            cnt       <= '0;
            resp_last <= is_write ? '0 : {CNT_W{1'b1}};
          end
        end
        RESP: if (tx_fire) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // The data shifter doubles as the response register once the bus phase is over.
  assign addr_shift      = (state == ADDR) && rx_fire;
  assign data_load       = ((state == IDLE) && rx_fire && !known_cmd) ||
                           ((state == XFER) && xfer_done);
  assign data_load_word  = (state == IDLE) ? {NAK_BYTE, 24'h0} :
                           is_write        ? {ACK_BYTE, 24'h0} : bus_din;
  assign data_shift      = ((state == DATA) && rx_fire) || ((state == RESP) && tx_fire);
  assign data_shift_byte = (state == RESP) ? 8'h00 : rx_data;

  plp_byte_shifter u_addr (
    .clk        (clk),
    .rst        (rst),
    .load       (1'b0),
    .load_word  (32'h0),
    .shift      (addr_shift),
    .shift_byte (rx_data),
    .word       (addr_word)
  );

  plp_byte_shifter u_data (
    .clk        (clk),
    .rst        (rst),
    .load       (data_load),
    .load_word  (data_load_word),
    .shift      (data_shift),
    .shift_byte (data_shift_byte),
    .word       (data_word)
  );

  assign bus_daddr = bus_phase ? word_align(addr_word) : '0;
  assign bus_dout  = bus_phase ? data_word : '0;
  assign tx_data   = (state == RESP) ? data_word[31:24] : '0;
  assign busy      = (state != IDLE);

endmodule
